// File: rtl/cpu_pkg.sv
// Shared constants and types for the hardwired control sequencer:
// opcodes, instruction classes, sequencer states and the strobe bundle.
package cpu_pkg;

  localparam int CPU_IR_W     = 32;
  localparam int CPU_OP_W     = 5;
  localparam int CPU_MAX_WAIT = 15;
  localparam int OPC_MSB      = CPU_IR_W - 1;
  localparam int OPC_LSB      = CPU_IR_W - CPU_OP_W;

  localparam logic [CPU_OP_W-1:0] OP_NOP  = 5'd0;
  localparam logic [CPU_OP_W-1:0] OP_ADD  = 5'd1;
  localparam logic [CPU_OP_W-1:0] OP_SUB  = 5'd2;
  localparam logic [CPU_OP_W-1:0] OP_AND  = 5'd3;
  localparam logic [CPU_OP_W-1:0] OP_OR   = 5'd4;
  localparam logic [CPU_OP_W-1:0] OP_SHR  = 5'd5;
  localparam logic [CPU_OP_W-1:0] OP_SHL  = 5'd6;
  localparam logic [CPU_OP_W-1:0] OP_ROR  = 5'd7;
  localparam logic [CPU_OP_W-1:0] OP_ROL  = 5'd8;
  localparam logic [CPU_OP_W-1:0] OP_ADDI = 5'd9;
  localparam logic [CPU_OP_W-1:0] OP_ANDI = 5'd10;
  localparam logic [CPU_OP_W-1:0] OP_ORI  = 5'd11;
  localparam logic [CPU_OP_W-1:0] OP_MUL  = 5'd12;
  localparam logic [CPU_OP_W-1:0] OP_DIV  = 5'd13;
  localparam logic [CPU_OP_W-1:0] OP_NEG  = 5'd14;
  localparam logic [CPU_OP_W-1:0] OP_NOT  = 5'd15;
  localparam logic [CPU_OP_W-1:0] OP_LD   = 5'd16;
  localparam logic [CPU_OP_W-1:0] OP_ST   = 5'd17;
  localparam logic [CPU_OP_W-1:0] OP_HALT = 5'd31;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT, ST_FAULT
  } state_t;

  typedef enum logic [2:0] {
    C_NOP, C_RTYPE, C_ITYPE, C_UNARY, C_MULDIV, C_LD, C_ST, C_HALT
  } op_class_t;

  typedef struct packed {
    logic pc_out, zlo_out, zhi_out, mdr_out, ba_out, c_out, r_out;
    logic pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, r_in, inc_pc;
    logic gra, grb, grc;
    logic read, write;
    logic [CPU_OP_W-1:0] op;
    logic run;
  } ctl_t;

endpackage

// File: rtl/control_sequencer_decode.sv
// Opcode to instruction-class decode; unknown opcodes fall through as NOP.
module op_class_decode
  import cpu_pkg::*;
(
  input  logic [CPU_OP_W-1:0] opcode,
  output op_class_t           cls
);

  always_comb begin
    cls = C_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = C_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:       cls = C_ITYPE;
      OP_NOT, OP_NEG:                 cls = C_UNARY;
      OP_MUL, OP_DIV:                 cls = C_MULDIV;
      OP_LD:                          cls = C_LD;
      OP_ST:                          cls = C_ST;
      OP_HALT:                        cls = C_HALT;
      default:                        cls = C_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for the 32-bit bus datapath. All strobes
// are a pure decode of the registered state and the IR opcode.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int IR_W     = CPU_IR_W,
  parameter int OP_W     = CPU_OP_W,
  parameter int MAX_WAIT = CPU_MAX_WAIT
) (
  input  logic            clk,
  input  logic            clear_n,
  input  logic [IR_W-1:0] ir,
  input  logic            mem_ready,
  input  logic            stop,
  output logic            PCout, Zlowout, Zhighout, MDRout, BAout, Cout, Rout,
  output logic            PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin, IncPC,
  output logic            Gra, Grb, Grc,
  output logic            Read, Write,
  output logic [OP_W-1:0] Operator,
  output logic            run
);

  state_t          state, state_nxt, adv;
  logic [3:0]      wait_cnt, wait_cnt_nxt;
  logic            mem_wait, last;
  op_class_t       cls;
  logic [OP_W-1:0] opc;
  logic            unused_ir;
  ctl_t            ctl;

  assign opc       = ir[IR_W-1 -: OP_W];
  assign unused_ir = ^ir[IR_W-OP_W-1:0];

  op_class_decode u_dec (.opcode(opc), .cls(cls));

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state    <= ST_RST;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // adv is the successor when memory is not holding us; wait states override it.
  always_comb begin
    adv      = ST_T0;
    mem_wait = 1'b0;
    last     = 1'b0;
    case (state)
      ST_RST: adv = ST_T0;
      ST_T0:  adv = ST_T1;
      ST_T1:  begin adv = ST_T2; mem_wait = 1'b1; end
      ST_T2:  begin
        case (cls)
          C_NOP:   adv = ST_T0;
          C_HALT:  adv = ST_HALT;
          default: adv = ST_T3;
        endcase
      end
      ST_T3:  adv = ST_T4;
      ST_T4:  begin adv = ST_T5; last = (cls == C_UNARY); end
      ST_T5:  begin adv = ST_T6; last = (cls == C_RTYPE) || (cls == C_ITYPE); end
      ST_T6:  begin adv = ST_T7; last = (cls == C_MULDIV); mem_wait = (cls == C_LD); end
      ST_T7:  begin last = 1'b1; mem_wait = (cls == C_ST); end
      ST_HALT:  adv = ST_HALT;
      ST_FAULT: adv = ST_FAULT;
      default:  adv = ST_FAULT;
    endcase
    if (last) adv = stop ? ST_HALT : ST_T0;

    state_nxt    = adv;
    wait_cnt_nxt = '0;
    if (mem_wait && !mem_ready) begin
      if (wait_cnt == 4'(MAX_WAIT)) state_nxt = ST_FAULT;
      else begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    ctl = '0;
    case (state)
      ST_T0: begin ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; ctl.z_in = 1'b1; end
      ST_T1: begin ctl.zlo_out = 1'b1; ctl.pc_in = 1'b1; ctl.read = 1'b1; ctl.mdr_in = 1'b1; end
      ST_T2: begin ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1; end
      ST_T3: begin
        case (cls)
          C_RTYPE, C_ITYPE: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1; end
          C_LD, C_ST:       begin ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1; end
          C_UNARY:  begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; ctl.op = opc; end
          C_MULDIV: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1; end
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls)
          C_RTYPE:  begin ctl.grc = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; ctl.op = opc; end
          C_ITYPE:  begin ctl.c_out = 1'b1; ctl.z_in = 1'b1; ctl.op = opc; end
          C_UNARY:  begin ctl.zlo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
          C_MULDIV: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; ctl.op = opc; end
          C_LD, C_ST: begin ctl.c_out = 1'b1; ctl.z_in = 1'b1; ctl.op = OP_ADD; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (cls)
          C_RTYPE, C_ITYPE: begin ctl.zlo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
          C_MULDIV:         begin ctl.zlo_out = 1'b1; ctl.lo_in = 1'b1; end
          C_LD, C_ST:       begin ctl.zlo_out = 1'b1; ctl.mar_in = 1'b1; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (cls)
          C_MULDIV: begin ctl.zhi_out = 1'b1; ctl.hi_in = 1'b1; end
          C_LD:     begin ctl.read = 1'b1; ctl.mdr_in = 1'b1; end
          C_ST:     begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.mdr_in = 1'b1; end
          default: ;
        endcase
      end
      ST_T7: begin
        case (cls)
          C_LD:    begin ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
          C_ST:    ctl.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    ctl.run = !(state inside {ST_RST, ST_HALT, ST_FAULT});
  end

  assign PCout    = ctl.pc_out;
  assign Zlowout  = ctl.zlo_out;
  assign Zhighout = ctl.zhi_out;
  assign MDRout   = ctl.mdr_out;
  assign BAout    = ctl.ba_out;
  assign Cout     = ctl.c_out;
  assign Rout     = ctl.r_out;
  assign PCin     = ctl.pc_in;
  assign MARin    = ctl.mar_in;
  assign MDRin    = ctl.mdr_in;
  assign IRin     = ctl.ir_in;
  assign Yin      = ctl.y_in;
  assign Zin      = ctl.z_in;
  assign HIin     = ctl.hi_in;
  assign LOin     = ctl.lo_in;
  assign Rin      = ctl.r_in;
  assign IncPC    = ctl.inc_pc;
  assign Gra      = ctl.gra;
  assign Grb      = ctl.grb;
  assign Grc      = ctl.grc;
  assign Read     = ctl.read;
  assign Write    = ctl.write;
  assign Operator = ctl.op;
  assign run      = ctl.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a table of per-cycle strobe words per
// instruction, plus hand sequences for reset abort, memory waits, FAULT and HALT.
module tb_control_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0, clear_n = 1'b0, mem_ready = 1'b1, stop = 1'b0;
  logic [31:0] ir = '0;
  logic PCout, Zlowout, Zhighout, MDRout, BAout, Cout, Rout;
  logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin, IncPC;
  logic Gra, Grb, Grc, Read, Write, run;
  logic [4:0] Operator;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .clear_n(clear_n), .ir(ir), .mem_ready(mem_ready), .stop(stop),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .BAout(BAout), .Cout(Cout), .Rout(Rout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .Rin(Rin), .IncPC(IncPC),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read), .Write(Write),
    .Operator(Operator), .run(run)
  );

  localparam logic [21:0] PCOUT = 22'h000001, ZLO   = 22'h000002, ZHI   = 22'h000004;
  localparam logic [21:0] MDROUT= 22'h000008, BAOUT = 22'h000010, COUT  = 22'h000020;
  localparam logic [21:0] ROUT  = 22'h000040, PCIN  = 22'h000080, MARIN = 22'h000100;
  localparam logic [21:0] MDRIN = 22'h000200, IRIN  = 22'h000400, YIN   = 22'h000800;
  localparam logic [21:0] ZIN   = 22'h001000, HIIN  = 22'h002000, LOIN  = 22'h004000;
  localparam logic [21:0] RIN   = 22'h008000, INCPC = 22'h010000, GRA   = 22'h020000;
  localparam logic [21:0] GRB   = 22'h040000, GRC   = 22'h080000, READ  = 22'h100000;
  localparam logic [21:0] WRITE = 22'h200000;
  localparam logic [21:0] F0 = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [21:0] F1 = ZLO | PCIN | READ | MDRIN;
  localparam logic [21:0] F2 = MDROUT | IRIN;

  logic [27:0] obs;
  assign obs = {run, Operator, Write, Read, Grc, Grb, Gra, IncPC, Rin, LOin, HIin, Zin,
                Yin, IRin, MDRin, MARin, PCin, Rout, Cout, BAout, MDRout, Zhighout,
                Zlowout, PCout};

  int n_vec = 0, n_bad = 0, rw_both = 0;

  always @(negedge clk) if (Read && Write) rw_both++;

  function automatic logic [27:0] e(input logic [4:0] op, input logic [21:0] s);
    return {1'b1, op, s};
  endfunction

  task automatic check(input string nm, input logic [27:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0]       ir;
    int                n;
    logic [7:0][27:0]  exp;
  } vec_t;
  vec_t tv[$];

  task automatic push(input logic [4:0] op, input int n, input logic [27:0] x3, x4, x5, x6, x7);
    vec_t v;
    v.ir = {op, 27'h1234567};
    v.n  = n;
    v.exp[0] = e(5'd0, F0); v.exp[1] = e(5'd0, F1); v.exp[2] = e(5'd0, F2);
    v.exp[3] = x3; v.exp[4] = x4; v.exp[5] = x5; v.exp[6] = x6; v.exp[7] = x7;
    tv.push_back(v);
  endtask

  // Checks cycles lo..hi of vector idx, one per falling edge. With lo>0 the
  // caller must be sitting in T0 so the new IR is in place before T2.
  task automatic run_vec(input int idx, input int lo, input int hi);
    if (lo > 0) ir = tv[idx].ir;
    for (int c = lo; c <= hi; c++) begin
      @(negedge clk);
      check($sformatf("v%0d.t%0d", idx, c), tv[idx].exp[c]);
      if (c == 0) ir = tv[idx].ir;
    end
  endtask

  task automatic pulse_reset();
    clear_n = 1'b0;
    #1 check("reset_async", 28'd0);
    @(negedge clk); clear_n = 1'b1;
    @(negedge clk); check("t0_after_reset", e(5'd0, F0));
  endtask

  localparam int V_ADD = 0, V_MUL = 5, V_LD = 7, V_ST = 8;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    push(OP_ADD,  6, e(0, GRB|ROUT|YIN), e(OP_ADD, GRC|ROUT|ZIN), e(0, ZLO|GRA|RIN), 0, 0);
    push(OP_SHL,  6, e(0, GRB|ROUT|YIN), e(OP_SHL, GRC|ROUT|ZIN), e(0, ZLO|GRA|RIN), 0, 0);
    push(OP_ADDI, 6, e(0, GRB|ROUT|YIN), e(OP_ADDI, COUT|ZIN),    e(0, ZLO|GRA|RIN), 0, 0);
    push(OP_NOT,  5, e(OP_NOT, GRB|ROUT|ZIN), e(0, ZLO|GRA|RIN), 0, 0, 0);
    push(OP_NEG,  5, e(OP_NEG, GRB|ROUT|ZIN), e(0, ZLO|GRA|RIN), 0, 0, 0);
    push(OP_MUL,  7, e(0, GRA|ROUT|YIN), e(OP_MUL, GRB|ROUT|ZIN), e(0, ZLO|LOIN), e(0, ZHI|HIIN), 0);
    push(OP_DIV,  7, e(0, GRA|ROUT|YIN), e(OP_DIV, GRB|ROUT|ZIN), e(0, ZLO|LOIN), e(0, ZHI|HIIN), 0);
    push(OP_LD,   8, e(0, GRB|BAOUT|YIN), e(OP_ADD, COUT|ZIN), e(0, ZLO|MARIN),
                     e(0, READ|MDRIN), e(0, MDROUT|GRA|RIN));
    push(OP_ST,   8, e(0, GRB|BAOUT|YIN), e(OP_ADD, COUT|ZIN), e(0, ZLO|MARIN),
                     e(0, GRA|ROUT|MDRIN), e(0, WRITE));
    push(OP_NOP,  3, 0, 0, 0, 0, 0);
    push(5'd20,   3, 0, 0, 0, 0, 0);
    push(OP_ORI,  6, e(0, GRB|ROUT|YIN), e(OP_ORI, COUT|ZIN),     e(0, ZLO|GRA|RIN), 0, 0);

    @(negedge clk); check("reset_state", 28'd0);
    @(negedge clk); clear_n = 1'b1;
    #1 check("rst_before_edge", 28'd0);

    foreach (tv[i]) run_vec(i, 0, tv[i].n - 1);

    // Reset lands in the middle of ADD T4.
    run_vec(V_ADD, 0, 4);
    #2 clear_n = 1'b0;
    #1 check("abort_mid_t4", 28'd0);
    @(negedge clk); check("held_in_reset", 28'd0);
    clear_n = 1'b1;
    #1 check("rst_after_release", 28'd0);
    @(negedge clk); check("t0_after_abort", e(5'd0, F0));

    // LD: memory not ready for 3 edges in T6.
    run_vec(V_LD, 1, 5);
    @(negedge clk); check("ld_t6", e(0, READ|MDRIN));
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check($sformatf("ld_t6_hold%0d", k), e(0, READ|MDRIN));
    end
    mem_ready = 1'b1;
    @(negedge clk); check("ld_t7", e(0, MDROUT|GRA|RIN));
    @(negedge clk); check("ld_back_t0", e(0, F0));

    // ST: one wait cycle in T7, Write held.
    run_vec(V_ST, 1, 6);
    @(negedge clk); check("st_t7", e(0, WRITE));
    mem_ready = 1'b0;
    @(negedge clk); check("st_t7_hold", e(0, WRITE));
    mem_ready = 1'b1;
    @(negedge clk); check("st_back_t0", e(0, F0));

    // stop raised during MUL T4: T5/T6 still complete, then HALT.
    run_vec(V_MUL, 1, 4);
    stop = 1'b1;
    run_vec(V_MUL, 5, 6);
    @(negedge clk); check("mul_halt", 28'd0);
    stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check($sformatf("halt_sticky%0d", k), 28'd0);
    end
    pulse_reset();

    // HALT opcode: halted where T3 would be.
    ir = {OP_HALT, 27'h0};
    @(negedge clk); check("halt_op_t1", e(0, F1));
    @(negedge clk); check("halt_op_t2", e(0, F2));
    @(negedge clk); check("halt_op_t3", 28'd0);
    @(negedge clk); check("halt_op_stay", 28'd0);
    pulse_reset();

    // Memory stuck during fetch: 16 cycles in T1, then FAULT.
    mem_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); check($sformatf("t1_wait%0d", k), e(0, F1));
    end
    @(negedge clk); check("fault", 28'd0);
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check($sformatf("fault_sticky%0d", k), 28'd0);
    end
    pulse_reset();
    run_vec(V_ADD, 1, 5);
    @(negedge clk); check("recovered_t0", e(0, F0));

    n_vec++;
    if (rw_both != 0) begin
      n_bad++;
      $display("FAIL read_write_overlap: got %0d cycles want 0", rw_both);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
